// File: rtl/placement_pkg.sv
// placement_pkg: shared widths, grid constants, flag bit positions and readback FSM encoding
package placement_pkg;
   localparam int W         = 32;
   localparam int N         = 9;
   localparam int NUM_NODES = 11;
   localparam logic signed [W-1:0] UNPLACED = -1;
   localparam int FLAG_UNPLACED = 0;
   localparam int FLAG_RANGE    = 1;
   localparam int FLAG_MISMATCH = 2;
   typedef enum logic [2:0] {
      S_IDLE, S_RD_POS, S_CHK_POS, S_RD_GRID, S_CHK_GRID, S_EMIT, S_DONE
   } state_t;
endpackage

// File: rtl/grid_index.sv
// grid_index: combinational x*N+y cell index plus in-range check of a signed position
module grid_index #(
   parameter int N = 9,
   parameter int W = 32
) (
   input  logic signed [W-1:0] i_x,
   input  logic signed [W-1:0] i_y,
   output logic signed [W-1:0] o_idx,
   output logic                o_in_range
);
   localparam logic signed [W-1:0] NS = W'(N);
   assign o_idx      = i_x * NS + i_y;
   assign o_in_range = (i_x >= 0) && (i_x < NS) && (i_y >= 0) && (i_y < NS);
endmodule

// File: rtl/placement_readback.sv
// placement_readback: scans every node, reads back its position, cross-checks the grid and streams one record per node
module placement_readback
   import placement_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                re_pos,
   output logic [W-1:0]        addr_pos,
   input  logic signed [W-1:0] dout_px,
   input  logic signed [W-1:0] dout_py,
   output logic                re_grid,
   output logic [W-1:0]        addr_grid,
   input  logic [W-1:0]        dout_grid,
   output logic                rec_valid,
   input  logic                rec_ready,
   output logic [W-1:0]        rec_node,
   output logic [W-1:0]        rec_x,
   output logic [W-1:0]        rec_y,
   output logic [2:0]          rec_flags,
   output logic [W-1:0]        err_count,
   output logic [W-1:0]        placed_count
);
   state_t r_state, w_next;
   logic [W-1:0] r_id, r_addr_grid, r_x, r_y, r_err, r_placed;
   logic [2:0]   r_flags;
   logic signed [W-1:0] w_idx;
   logic w_in_range, w_unplaced, w_hs, w_last;

   grid_index #(.N(N), .W(W)) u_idx (
      .i_x(dout_px), .i_y(dout_py), .o_idx(w_idx), .o_in_range(w_in_range)
   );

   assign w_unplaced = (dout_px == UNPLACED) || (dout_py == UNPLACED);
   assign w_hs       = (r_state == S_EMIT) && rec_ready;
   assign w_last     = r_id == W'(NUM_NODES - 1);

   // state register; an asynchronous reset aborts any scan in progress
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= S_IDLE;
      else r_state <= w_next;

   // next-state and strobe/status decode
   always_comb begin
      w_next    = r_state;
      busy      = (r_state != S_IDLE) && (r_state != S_DONE);
      done      = r_state == S_DONE;
      re_pos    = r_state == S_RD_POS;
      re_grid   = r_state == S_RD_GRID;
      rec_valid = r_state == S_EMIT;
      case (r_state)
         S_IDLE:     w_next = start ? S_RD_POS : S_IDLE;
         S_RD_POS:   w_next = S_CHK_POS;
         S_CHK_POS:  w_next = (w_unplaced || !w_in_range) ? S_EMIT : S_RD_GRID;
         S_RD_GRID:  w_next = S_CHK_GRID;
         S_CHK_GRID: w_next = S_EMIT;
         S_EMIT:     w_next = !w_hs ? S_EMIT : w_last ? S_DONE : S_RD_POS;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // datapath: node id, latched position, flags, grid address and counters
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_id        <= '0;
         r_addr_grid <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_flags     <= '0;
         r_err       <= '0;
         r_placed    <= '0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_id     <= '0;
            r_err    <= '0;
            r_placed <= '0;
         end
         if (r_state == S_CHK_POS) begin
            r_x     <= dout_px;
            r_y     <= dout_py;
            r_flags <= w_unplaced ? 3'(1 << FLAG_UNPLACED) : !w_in_range ? 3'(1 << FLAG_RANGE) : 3'b000;
            if (!w_unplaced && w_in_range) r_addr_grid <= w_idx;
         end
         if (r_state == S_CHK_GRID) r_flags <= (dout_grid != r_id) ? 3'(1 << FLAG_MISMATCH) : 3'b000;
         if (w_hs) begin
            if (r_flags[FLAG_RANGE] || r_flags[FLAG_MISMATCH]) r_err <= r_err + W'(1);
            if (r_flags == 3'b000) r_placed <= r_placed + W'(1);
            if (!w_last) r_id <= r_id + W'(1);
         end
      end

   assign addr_pos     = r_id;
   assign addr_grid    = r_addr_grid;
   assign rec_node     = r_id;
   assign rec_x        = r_x;
   assign rec_y        = r_y;
   assign rec_flags    = r_flags;
   assign err_count    = r_err;
   assign placed_count = r_placed;
endmodule

// File: tb/tb_placement_readback.sv
// tb_placement_readback: scoreboard bench with RAM models, backpressure and mid-scan reset scenarios
module tb_placement_readback;
   import placement_pkg::*;

   typedef struct {
      int node;
      int x;
      int y;
      logic [2:0] flags;
   } rec_t;

   logic clk = 0, reset = 0, start = 0, rec_ready = 1;
   logic busy, done, re_pos, re_grid, rec_valid;
   logic [W-1:0] addr_pos, addr_grid, rec_node, rec_x, rec_y, err_count, placed_count;
   logic signed [W-1:0] dout_px = 0, dout_py = 0;
   logic [W-1:0] dout_grid = 0;
   logic [2:0] rec_flags;

   int px [NUM_NODES];
   int py [NUM_NODES];
   int grid [N*N];
   rec_t exp_q [$];
   int exp_err, exp_placed, exp_cyc;
   int checks = 0, failures = 0;
   bit gread [NUM_NODES];
   int gaddr [NUM_NODES];
   int done_cyc;

   placement_readback dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .re_pos(re_pos), .addr_pos(addr_pos), .dout_px(dout_px), .dout_py(dout_py),
      .re_grid(re_grid), .addr_grid(addr_grid), .dout_grid(dout_grid),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_node(rec_node),
      .rec_x(rec_x), .rec_y(rec_y), .rec_flags(rec_flags),
      .err_count(err_count), .placed_count(placed_count)
   );

   always #5 clk = ~clk;

   // memory models: data appears the cycle after the strobe and is held until the next read
   always @(posedge clk) begin
      if (re_pos && addr_pos < NUM_NODES) begin
         dout_px <= px[addr_pos];
         dout_py <= py[addr_pos];
      end
      if (re_grid && addr_grid < N*N) dout_grid <= grid[addr_grid];
   end

   function automatic logic [2:0] model_flags(int k);
      int x = px[k], y = py[k];
      if (x == -1 || y == -1) return 3'b001;
      if (x < 0 || x > N-1 || y < 0 || y > N-1) return 3'b010;
      return (grid[x*N+y] != k) ? 3'b100 : 3'b000;
   endfunction

   task automatic setup_base();
      for (int i = 0; i < N*N; i++) grid[i] = -1;
      for (int k = 0; k < NUM_NODES; k++) begin
         px[k] = k / 3;
         py[k] = k % 3;
         grid[px[k]*N + py[k]] = k;
      end
   endtask

   task automatic push_expected();
      rec_t r;
      exp_q.delete();
      exp_err = 0; exp_placed = 0; exp_cyc = 0;
      for (int k = 0; k < NUM_NODES; k++) begin
         r.node = k; r.x = px[k]; r.y = py[k]; r.flags = model_flags(k);
         exp_q.push_back(r);
         if (r.flags[1] || r.flags[2]) exp_err++;
         if (r.flags == 3'b000) exp_placed++;
         exp_cyc += (r.flags[0] || r.flags[1]) ? 3 : 5;
      end
   endtask

   task automatic run_scan(input bit bp);
      rec_t e;
      int cyc = 0, cur = 0, stall = 0;
      bit stalled = 0;
      logic [W-1:0] h_node, h_x, h_y;
      logic [2:0] h_flags;
      done_cyc = -1;
      for (int k = 0; k < NUM_NODES; k++) begin gread[k] = 0; gaddr[k] = -1; end
      @(negedge clk);
      start = 1;
      rec_ready = !bp;
      @(negedge clk);
      start = 0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b want=1", busy); end
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         cyc++;
         start = bp && (cyc == 7 || cyc == 20);
         if (bp) begin
            rec_ready = (stall < 4) ? 1'b0 : ~rec_ready;
            if (rec_valid && !rec_ready) stall++;
         end
         if (re_pos) cur = int'(addr_pos);
         if (re_grid && cur < NUM_NODES) begin gread[cur] = 1; gaddr[cur] = int'(addr_grid); end
         if (stalled) begin
            checks++;
            if (rec_valid !== 1'b1 || rec_node !== h_node || rec_x !== h_x || rec_y !== h_y || rec_flags !== h_flags) begin
               failures++;
               $display("FAIL stall_stable got v=%b n=%0d x=%0d y=%0d f=%b want v=1 n=%0d x=%0d y=%0d f=%b",
                        rec_valid, rec_node, $signed(rec_x), $signed(rec_y), rec_flags, h_node, $signed(h_x), $signed(h_y), h_flags);
            end
         end
         stalled = rec_valid && !rec_ready;
         h_node = rec_node; h_x = rec_x; h_y = rec_y; h_flags = rec_flags;
         if (rec_valid && rec_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL extra_record got node=%0d want none", rec_node);
            end else begin
               e = exp_q.pop_front();
               if (rec_node !== W'(e.node) || rec_x !== W'(e.x) || rec_y !== W'(e.y) || rec_flags !== e.flags) begin
                  failures++;
                  $display("FAIL record got n=%0d x=%0d y=%0d f=%b want n=%0d x=%0d y=%0d f=%b",
                           rec_node, $signed(rec_x), $signed(rec_y), rec_flags, e.node, e.x, e.y, e.flags);
               end
            end
         end
         if (done) begin done_cyc = cyc; break; end
      end
      start = 0;
      rec_ready = 1;
      checks++;
      if (done_cyc < 0 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL scan_complete got done_cyc=%0d left=%0d want done and 0 left", done_cyc, exp_q.size());
      end
      checks++;
      if (err_count !== W'(exp_err) || placed_count !== W'(exp_placed)) begin
         failures++;
         $display("FAIL counts got err=%0d placed=%0d want err=%0d placed=%0d", err_count, placed_count, exp_err, exp_placed);
      end
   endtask

   task automatic test_reset();
      reset = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, re_pos, re_grid, rec_valid, addr_pos, addr_grid, rec_node, rec_x, rec_y, rec_flags, err_count, placed_count} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b vld=%b err=%0d placed=%0d want all zero", busy, done, rec_valid, err_count, placed_count);
      end
      reset = 1;
      @(negedge clk);
   endtask

   task automatic test_all_placed();
      setup_base();
      push_expected();
      run_scan(0);
      checks++;
      if (done_cyc !== 55) begin failures++; $display("FAIL done_latency got=%0d want=55", done_cyc); end
      checks++;
      if (placed_count !== 11 || err_count !== 0) begin
         failures++;
         $display("FAIL all_placed_counts got placed=%0d err=%0d want placed=11 err=0", placed_count, err_count);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy); end
      repeat (3) @(negedge clk);
      checks++;
      if (placed_count !== 11) begin failures++; $display("FAIL counts_held got=%0d want=11", placed_count); end
   endtask

   task automatic test_unplaced();
      setup_base();
      px[4] = -1; py[4] = -1;
      push_expected();
      run_scan(0);
      checks++;
      if (gread[4] !== 1'b0 || placed_count !== 10 || err_count !== 0 || done_cyc !== exp_cyc) begin
         failures++;
         $display("FAIL unplaced got gread=%b placed=%0d err=%0d cyc=%0d want 0 10 0 %0d", gread[4], placed_count, err_count, done_cyc, exp_cyc);
      end
   endtask

   task automatic test_out_of_range();
      setup_base();
      px[2] = 9; py[2] = 0;
      push_expected();
      run_scan(0);
      checks++;
      if (gread[2] !== 1'b0 || err_count !== 1 || done_cyc !== exp_cyc) begin
         failures++;
         $display("FAIL out_of_range got gread=%b err=%0d cyc=%0d want 0 1 %0d", gread[2], err_count, done_cyc, exp_cyc);
      end
   endtask

   task automatic test_mismatch();
      setup_base();
      px[3] = 1; py[3] = 1; grid[10] = 7;
      px[4] = 2; py[4] = 8; grid[26] = 4;
      push_expected();
      run_scan(0);
      checks++;
      if (gread[3] !== 1'b1 || gaddr[3] !== 10 || err_count !== 1 || placed_count !== 10) begin
         failures++;
         $display("FAIL mismatch got gread=%b addr=%0d err=%0d placed=%0d want 1 10 1 10", gread[3], gaddr[3], err_count, placed_count);
      end
   endtask

   task automatic test_backpressure();
      setup_base();
      push_expected();
      run_scan(1);
      checks++;
      if (done_cyc <= 55) begin failures++; $display("FAIL bp_latency got=%0d want >55", done_cyc); end
   endtask

   task automatic test_reset_mid();
      int cur = 0;
      bit found = 0;
      setup_base();
      @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      for (int t = 0; t < 200; t++) begin
         if (re_pos) cur = int'(addr_pos);
         if (re_grid && cur == 5) begin found = 1; break; end
         @(negedge clk);
      end
      checks++;
      if (!found) begin failures++; $display("FAIL reach_rd_grid_5 got=0 want=1"); end
      reset = 0;
      #1;
      checks++;
      if ({busy, done, re_pos, re_grid, rec_valid, addr_pos, addr_grid, rec_node, rec_x, rec_y, rec_flags, err_count, placed_count} !== '0) begin
         failures++;
         $display("FAIL midreset_outputs got busy=%b re_grid=%b addr_grid=%0d placed=%0d want all zero", busy, re_grid, addr_grid, placed_count);
      end
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         if (t == 3) reset = 1;
         checks++;
         if (done !== 1'b0) begin failures++; $display("FAIL no_partial_done got=%b want=0", done); end
      end
      push_expected();
      run_scan(0);
      checks++;
      if (done_cyc !== 55) begin failures++; $display("FAIL rescan_latency got=%0d want=55", done_cyc); end
   endtask

   initial begin
      test_reset();
      test_all_placed();
      test_unplaced();
      test_out_of_range();
      test_mismatch();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
